// File: rtl/sd_cmd_resp_rx.sv
// rtl/sd_cmd_resp_rx.sv - SD/SDIO CMD-line response receiver (48/136-bit frames, framing, timeout).
// Define SD_CMD_RESP_RX_CRC_EN to compile the CRC7 check; otherwise crc_err is tied to 0.
module sd_cmd_resp_rx #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         arm,
  input  logic         long_resp,
  input  logic         sample_en,
  input  logic         cmd_in,
  input  logic         start_pe,
  output logic         busy,
  output logic         done,
  output logic [135:0] resp,
  output logic         crc_err,
  output logic         frame_err,
  output logic         timeout
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT_CYC);
  localparam logic [TW-1:0] T_ONE = TW'(1);

  typedef enum logic [1:0] {IDLE, WAIT_START, SHIFT, CHECK} state_t;

  state_t         state_q, state_d;
  logic           long_q, long_d;
  logic           pend_q, pend_d;
  logic [7:0]     bcnt_q, bcnt_d;
  logic [TW-1:0]  tcnt_q, tcnt_d;
  logic [135:0]   resp_q, resp_d;
  logic           frame_err_q, frame_err_d;
  logic           timeout_q, timeout_d;
  logic [7:0]     bit_idx;
  logic [7:0]     frame_len;

`ifdef SD_CMD_RESP_RX_CRC_EN
  logic [6:0]     crc_q, crc_d;
  logic           crc_err_q, crc_err_d;

  function automatic logic [6:0] crc7_next(input logic [6:0] c, input logic b);
    logic fb;
    fb = c[6] ^ b;
    return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction
`endif

  always_comb begin
    state_d     = state_q;
    long_d      = long_q;
    pend_d      = pend_q;
    bcnt_d      = bcnt_q;
    tcnt_d      = tcnt_q;
    resp_d      = resp_q;
    frame_err_d = frame_err_q;
    timeout_d   = timeout_q;
`ifdef SD_CMD_RESP_RX_CRC_EN
    crc_d       = crc_q;
    crc_err_d   = crc_err_q;
`endif
    // 1-based index of the bit captured by the current strobe while shifting
    bit_idx   = bcnt_q + 8'd1;
    frame_len = long_q ? 8'd136 : 8'd48;

    case (state_q)
      IDLE: begin
        if (arm) begin
          state_d     = WAIT_START;
          long_d      = long_resp;
          pend_d      = 1'b0;
          bcnt_d      = 8'd0;
          tcnt_d      = '0;
          resp_d      = '0;
          frame_err_d = 1'b0;
          timeout_d   = 1'b0;
`ifdef SD_CMD_RESP_RX_CRC_EN
          crc_d       = 7'd0;
          crc_err_d   = 1'b0;
`endif
        end
      end
      WAIT_START: begin
        if (start_pe) pend_d = 1'b1;
        if (sample_en) begin
          if (!cmd_in && (start_pe || pend_q)) begin
            // start bit is 0, so folding it into a zero CRC leaves the CRC at 0
            resp_d  = {resp_q[134:0], cmd_in};
            bcnt_d  = 8'd1;
            pend_d  = 1'b0;
            state_d = SHIFT;
          end else begin
            tcnt_d = tcnt_q + T_ONE;
            if (tcnt_d == T_MAX) begin
              state_d   = CHECK;
              timeout_d = 1'b1;
            end
          end
        end
      end
      SHIFT: begin
        if (sample_en) begin
          resp_d = {resp_q[134:0], cmd_in};
          bcnt_d = bit_idx;
`ifdef SD_CMD_RESP_RX_CRC_EN
          if (long_q ? (bit_idx >= 8'd9 && bit_idx <= 8'd128) : (bit_idx <= 8'd40))
            crc_d = crc7_next(crc_q, cmd_in);
`endif
          if (bcnt_d == frame_len) begin
            state_d     = CHECK;
            frame_err_d = (long_q ? resp_d[135] : resp_d[47]) |
                          (long_q ? resp_d[134] : resp_d[46]) | ~resp_d[0];
`ifdef SD_CMD_RESP_RX_CRC_EN
            crc_err_d   = (crc_q != resp_d[7:1]);
`endif
          end
        end
      end
      CHECK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      long_q      <= 1'b0;
      pend_q      <= 1'b0;
      bcnt_q      <= 8'd0;
      tcnt_q      <= '0;
      resp_q      <= '0;
      frame_err_q <= 1'b0;
      timeout_q   <= 1'b0;
`ifdef SD_CMD_RESP_RX_CRC_EN
      crc_q       <= 7'd0;
      crc_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      long_q      <= long_d;
      pend_q      <= pend_d;
      bcnt_q      <= bcnt_d;
      tcnt_q      <= tcnt_d;
      resp_q      <= resp_d;
      frame_err_q <= frame_err_d;
      timeout_q   <= timeout_d;
`ifdef SD_CMD_RESP_RX_CRC_EN
      crc_q       <= crc_d;
      crc_err_q   <= crc_err_d;
`endif
    end
  end

  assign busy      = (state_q == WAIT_START) || (state_q == SHIFT);
  assign done      = (state_q == CHECK);
  assign resp      = resp_q;
  assign frame_err = frame_err_q;
  assign timeout   = timeout_q;
`ifdef SD_CMD_RESP_RX_CRC_EN
  assign crc_err   = crc_err_q;
`else
  assign crc_err   = 1'b0;
`endif

endmodule
